// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default widths for the sequence stimulus blocks
package seq_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;
    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_SHIFT = SHIFT,
        S_FIN   = FIN
    } state_t;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 5;
    localparam int DEF_DIV_W  = 8;
endpackage

// File: rtl/seq_stim_tx_if.sv
// seq_stim_tx_if: control/pattern inputs and serial/handshake outputs of seq_stim_tx
interface seq_stim_tx_if #(
    parameter int DATA_W = seq_pkg::DEF_DATA_W,
    parameter int LEN_W  = seq_pkg::DEF_LEN_W,
    parameter int DIV_W  = seq_pkg::DEF_DIV_W
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [DIV_W-1:0]  bit_div;
    logic              rpt;
    logic              x1;
    logic              bit_strobe;
    logic              busy;
    logic              done;
    logic              wrap;
    modport master (
        output start, abort, data, len, bit_div, rpt,
        input  x1, bit_strobe, busy, done, wrap
    );
    modport slave (
        input  start, abort, data, len, bit_div, rpt,
        output x1, bit_strobe, busy, done, wrap
    );
endinterface

// File: rtl/seq_stim_tx_bit_timer.sv
// bit_timer: loadable down-counter; tc is high while the count sits at zero
module bit_timer #(
    parameter int DIV_W = seq_pkg::DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);
    logic [DIV_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= div;
        else if (cnt != '0) cnt <= cnt - DIV_W'(1);
    end
    assign tc = cnt == '0;
endmodule

// File: rtl/seq_stim_tx.sv
// seq_stim_tx: shifts a captured pattern out MSB-first on x1, each bit held bit_div+1 cycles
module seq_stim_tx
    import seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input logic          clk,
    input logic          rst,
    seq_stim_tx_if.slave bus
);
    localparam int IDX_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
    state_t            state;
    logic [DATA_W-1:0] sh_data;
    logic [IDX_W-1:0]  sh_top;
    logic [DIV_W-1:0]  sh_div;
    logic              sh_rpt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_dn;
    logic [LEN_W-1:0]  len_c;
    logic [IDX_W-1:0]  top_in;
    logic              tc;
    logic              tm_load;
    logic [DIV_W-1:0]  tm_div;
    assign len_c   = bus.len > LEN_W'(DATA_W) ? LEN_W'(DATA_W) : bus.len;
    assign top_in  = IDX_W'(len_c - LEN_W'(1));
    assign idx_dn  = idx - IDX_W'(1);
    // Timer tracks the live bit_div while idle so the first bit gets the right period
    assign tm_load = state != S_SHIFT || tc;
    assign tm_div  = state == S_IDLE ? bus.bit_div : sh_div;
    bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk (clk),
        .rst (rst),
        .load(tm_load),
        .div (tm_div),
        .tc  (tc)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            sh_data        <= '0;
            sh_top         <= '0;
            sh_div         <= '0;
            sh_rpt         <= 1'b0;
            idx            <= '0;
            bus.x1         <= 1'b0;
            bus.bit_strobe <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.wrap       <= 1'b0;
        end else begin
            bus.bit_strobe <= 1'b0;
            bus.done       <= 1'b0;
            bus.wrap       <= 1'b0;
            case (state)
                S_IDLE: if (bus.start && !bus.abort) begin
                    sh_data <= bus.data;
                    sh_top  <= top_in;
                    sh_div  <= bus.bit_div;
                    sh_rpt  <= bus.rpt;
                    if (len_c == '0) begin
                        state    <= S_FIN;
                        bus.done <= 1'b1;
                    end else begin
                        state          <= S_SHIFT;
                        idx            <= top_in;
                        bus.x1         <= bus.data[top_in];
                        bus.busy       <= 1'b1;
                        bus.bit_strobe <= 1'b1;
                    end
                end
                S_SHIFT: if (bus.abort) begin
                    state    <= S_IDLE;
                    bus.x1   <= 1'b0;
                    bus.busy <= 1'b0;
                end else if (tc) begin
                    if (idx != '0) begin
                        idx            <= idx_dn;
                        bus.x1         <= sh_data[idx_dn];
                        bus.bit_strobe <= 1'b1;
                    end else if (sh_rpt) begin
                        idx            <= sh_top;
                        bus.x1         <= sh_data[sh_top];
                        bus.bit_strobe <= 1'b1;
                        bus.wrap       <= 1'b1;
                    end else begin
                        state    <= S_FIN;
                        bus.x1   <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_stim_tx.sv
// tb_seq_stim_tx: directed checks of seq_stim_tx outputs {x1,bit_strobe,busy,done,wrap}
module tb_seq_stim_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [4:0] obs;
    seq_stim_tx_if #(.DATA_W(16), .LEN_W(5), .DIV_W(8)) bus ();
    seq_stim_tx #(.DATA_W(16), .LEN_W(5), .DIV_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    assign obs = {bus.x1, bus.bit_strobe, bus.busy, bus.done, bus.wrap};
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask
    // Field 0 of v is the most significant 5-bit group of an n-entry concatenation
    task automatic expect_seq(input string tag, input int n, input logic [79:0] v);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d]", tag, i), obs, v[5*(n-1-i) +: 5]);
            tick();
        end
    endtask
    task automatic go(input logic [15:0] d, input logic [4:0] l, input logic [7:0] dv, input logic r);
        bus.data = d;
        bus.len = l;
        bus.bit_div = dv;
        bus.rpt = r;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.data = '0;
        bus.len = '0;
        bus.bit_div = '0;
        bus.rpt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset", obs, 5'b00000);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle[%0d]", i), obs, 5'b00000);
        end
        go(16'h0006, 5'd4, 8'd0, 1'b0);
        expect_seq("oneshot", 6, {5'b01100, 5'b11100, 5'b11100, 5'b01100, 5'b00010, 5'b00000});
        go(16'h0002, 5'd2, 8'd2, 1'b0);
        expect_seq("div", 8, {5'b11100, 5'b10100, 5'b10100, 5'b01100, 5'b00100, 5'b00100,
                              5'b00010, 5'b00000});
        go(16'h0005, 5'd3, 8'd0, 1'b1);
        expect_seq("rpt", 7, {5'b11100, 5'b01100, 5'b11100, 5'b11101, 5'b01100, 5'b11100,
                              5'b11101});
        bus.abort = 1'b1;
        expect_seq("rpt_ab", 1, {5'b01100});
        bus.abort = 1'b0;
        bus.rpt = 1'b0;
        expect_seq("post_abort", 4, {5'b00000, 5'b00000, 5'b00000, 5'b00000});
        go(16'hFFFF, 5'd0, 8'd3, 1'b0);
        expect_seq("len0", 3, {5'b00010, 5'b00000, 5'b00000});
        go(16'h0009, 5'd4, 8'd1, 1'b0);
        expect_seq("busy_a", 2, {5'b11100, 5'b10100});
        bus.start = 1'b1;
        bus.data = 16'hFFFF;
        bus.len = 5'd2;
        expect_seq("busy_b", 1, {5'b01100});
        bus.start = 1'b0;
        expect_seq("busy_c", 7, {5'b00100, 5'b01100, 5'b00100, 5'b11100, 5'b10100, 5'b00010,
                                 5'b00000});
        bus.data = 16'h0001;
        bus.len = 5'd1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        expect_seq("st_ab", 3, {5'b00000, 5'b00000, 5'b00000});
        go(16'h8001, 5'd31, 8'd0, 1'b0);
        expect_seq("clamp", 2, {5'b11100, 5'b01100});
        bus.abort = 1'b1;
        expect_seq("clamp_ab", 1, {5'b01100});
        bus.abort = 1'b0;
        expect_seq("clamp_idle", 1, {5'b00000});
        go(16'h00C3, 5'd8, 8'd0, 1'b0);
        expect_seq("mid_a", 2, {5'b11100, 5'b11100});
        chk("mid_bit2", obs, 5'b01100);
        rst = 1'b1;
        #1;
        chk("rst_async", obs, 5'b00000);
        tick();
        chk("rst_hold", obs, 5'b00000);
        rst = 1'b0;
        tick();
        go(16'h0081, 5'd8, 8'd0, 1'b0);
        expect_seq("after_rst", 10, {5'b11100, 5'b01100, 5'b01100, 5'b01100, 5'b01100,
                                     5'b01100, 5'b01100, 5'b11100, 5'b00010, 5'b00000});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
